// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, the canonical NOP
// (ADDI x0,x0,0), the PC increment and the fetch FSM state encoding.
package riscv_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_HOLD
  } fetch_state_e;
endpackage

// File: rtl/perf_counter.sv
// Free-running event counter.
//   clk   : clock
//   reset : synchronous, active-high; clears count
//   en    : count one event this cycle
//   count : current value, wraps at 2^WIDTH
module perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset)   count <= '0;
    else if (en) count <= count + 1'b1;
  end
endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch stage. Owns the PC, issues one word
// request at a time, captures the response into an instruction register and
// hands {instr, instr_pc} to decode on a valid/ready handshake. Redirects
// from execute restart fetch and squash whatever is in flight.
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   imem_req/addr/gnt          : request channel (held until granted)
//   imem_rvalid/rdata          : response channel (one beat per grant)
//   redirect_valid/redirect_pc : restart fetch at redirect_pc (bits[1:0] dropped)
//   instr_valid/instr/instr_pc : to decode, registered, NOP_INSTR when invalid
//   dec_ready                  : decode consumes when instr_valid & dec_ready
//
// Build option IFETCH_PERF_EN adds perf_fetched (instructions handed to
// decode) and perf_stall (cycles spent in REQ or WAIT).
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      imem_req,
  output logic [riscv_pkg::XLEN-1:0] imem_addr,
  input  logic                      imem_gnt,
  input  logic                      imem_rvalid,
  input  logic [riscv_pkg::XLEN-1:0] imem_rdata,
  input  logic                      redirect_valid,
  input  logic [riscv_pkg::XLEN-1:0] redirect_pc,
  output logic                      instr_valid,
  output logic [riscv_pkg::XLEN-1:0] instr,
  output logic [riscv_pkg::XLEN-1:0] instr_pc,
`ifdef IFETCH_PERF_EN
  output logic [31:0]               perf_fetched,
  output logic [31:0]               perf_stall,
`endif
  input  logic                      dec_ready
);
  import riscv_pkg::*;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            discard;  // a redirect hit WAIT: drop the next response
  logic [XLEN-1:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & ~32'h3;
  assign imem_addr    = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FS_REQ;
      pc          <= RESET_PC;
      discard     <= 1'b0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= RESET_PC;
    end else begin
      unique case (state)
        FS_REQ: begin
          // A redirect voids a same-cycle grant; the request stays up and
          // moves to the new address.
          if (redirect_valid) begin
            pc       <= redirect_tgt;
            imem_req <= 1'b1;
          end else if (imem_req && imem_gnt) begin
            state    <= FS_WAIT;
            imem_req <= 1'b0;
          end else begin
            imem_req <= 1'b1;
          end
        end
        FS_WAIT: begin
          if (redirect_valid) pc <= redirect_tgt;
          if (imem_rvalid) begin
            discard <= 1'b0;
            if (discard || redirect_valid) begin
              // Stale word: refetch from the (possibly new) pc.
              state    <= FS_REQ;
              imem_req <= 1'b1;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              pc          <= pc + PC_STEP;
              instr_valid <= 1'b1;
              state       <= FS_HOLD;
            end
          end else if (redirect_valid) begin
            discard <= 1'b1;
          end
        end
        FS_HOLD: begin
          if (redirect_valid || dec_ready) begin
            if (redirect_valid) pc <= redirect_tgt;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            state       <= FS_REQ;
            imem_req    <= 1'b1;
          end
        end
        default: begin
          state    <= FS_REQ;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  perf_counter #(.WIDTH(32)) u_perf_fetched (
    .clk   (clk),
    .reset (reset),
    .en    (instr_valid & dec_ready),
    .count (perf_fetched)
  );

  perf_counter #(.WIDTH(32)) u_perf_stall (
    .clk   (clk),
    .reset (reset),
    .en    ((state == FS_REQ) || (state == FS_WAIT)),
    .count (perf_stall)
  );
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a behavioural memory grants every
// request and answers after a programmable latency; the main sequence steps
// cycle by cycle and compares outputs against hand-computed values.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        dec_ready;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
`ifdef IFETCH_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
`endif
    .dec_ready      (dec_ready)
  );

  // Memory model: always grants; response 'lat' cycles after the grant.
  int          lat = 1;
  int          cnt = 0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;
  logic [31:0] rsp_addr = 32'h0;

  assign imem_gnt = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = 32'h0000_0093;
      32'h4:   mem_word = 32'h0010_0113;
      default: mem_word = a ^ 32'h1357_0000;
    endcase
  endfunction

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  end

  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (cnt != 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ovr_en ? ovr_data : mem_word(rsp_addr);
      end
    end
    // A grant coinciding with a redirect is void.
    if (imem_req && imem_gnt && !redirect_valid) begin
      cnt      = lat;
      rsp_addr = imem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; dec_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    reset = 1'b0;

    // Back-to-back fetch, one instruction every 3 cycles.
    tick();
    chk("f0_req", {31'h0, imem_req}, 32'h1);
    chk("f0_addr", imem_addr, 32'h0);
    tick();
    chk("f0_wait_req", {31'h0, imem_req}, 32'h0);
    tick();
    chk("f0_valid", {31'h0, instr_valid}, 32'h1);
    chk("f0_instr", instr, 32'h0000_0093);
    chk("f0_pc", instr_pc, 32'h0);
    tick();
    chk("f1_valid", {31'h0, instr_valid}, 32'h0);
    chk("f1_addr", imem_addr, 32'h4);
    chk("f1_req", {31'h0, imem_req}, 32'h1);
    tick(); tick();
    chk("f1_instr", instr, 32'h0010_0113);
    chk("f1_pc", instr_pc, 32'h4);

    // Decode back-pressure: held word stays put, no new request.
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", {31'h0, instr_valid}, 32'h1);
      chk("hold_instr", instr, 32'h0010_0113);
      chk("hold_pc", instr_pc, 32'h4);
      chk("hold_req", {31'h0, imem_req}, 32'h0);
    end
    dec_ready = 1'b1;
    tick();
    chk("f2_addr", imem_addr, 32'h8);
    chk("f2_req", {31'h0, imem_req}, 32'h1);
    lat = 3;

    // Redirect while waiting: late response is dropped.
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF; lat = 1;
    tick();
    redirect_valid = 1'b0;
    chk("rw_valid_a", {31'h0, instr_valid}, 32'h0);
    chk("rw_req_a", {31'h0, imem_req}, 32'h0);
    tick();
    chk("rw_valid_b", {31'h0, instr_valid}, 32'h0);
    tick();
    ovr_en = 1'b0;
    chk("rw_req", {31'h0, imem_req}, 32'h1);
    chk("rw_addr", imem_addr, 32'h100);
    chk("rw_valid_c", {31'h0, instr_valid}, 32'h0);
    tick(); tick();
    chk("rw_dvalid", {31'h0, instr_valid}, 32'h1);
    chk("rw_dpc", instr_pc, 32'h100);
    chk("rw_dinstr", instr, 32'h1357_0100);

    // Redirect in HOLD with dec_ready: squash, target forced aligned.
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    chk("rh_valid", {31'h0, instr_valid}, 32'h0);
    chk("rh_instr", instr, NOP);
    chk("rh_addr", imem_addr, 32'h200);
    // Redirect while requesting: grant voided, address moves.
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("rq_req", {31'h0, imem_req}, 32'h1);
    chk("rq_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); tick();
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", instr, 32'hECA8_FFFC);
    lat = 2;
    tick();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req", {31'h0, imem_req}, 32'h1);

    // Reset during WAIT, stray response afterwards.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; lat = 1;
    chk("mr_req", {31'h0, imem_req}, 32'h0);
    chk("mr_valid", {31'h0, instr_valid}, 32'h0);
    chk("mr_instr", instr, NOP);
`ifdef IFETCH_PERF_EN
    chk("mr_perf", perf_fetched, 32'h0);
`endif
    tick();
    chk("mr_valid2", {31'h0, instr_valid}, 32'h0);
    chk("mr_req2", {31'h0, imem_req}, 32'h1);
    chk("mr_addr", imem_addr, 32'h0);
    tick(); tick();
    chk("mr_dvalid", {31'h0, instr_valid}, 32'h1);
    chk("mr_dinstr", instr, 32'h0000_0093);
    chk("mr_dpc", instr_pc, 32'h0);
`ifdef IFETCH_PERF_EN
    tick();
    chk("perf_fetch1", perf_fetched, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
